// File: rtl/aqua_mem_pkg.sv
// Shared definitions for the aqua memory controller: state encodings, byte-lane
// geometry and word-index slice constants reused by neighbouring blocks.
package aqua_mem_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_RESP   = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_WAIT   = ST_WAIT,
        S_ACCESS = ST_ACCESS,
        S_RESP   = ST_RESP,
        S_ERR    = ST_ERR
    } mem_state_e;

    localparam int BYTE_LANES = 4;
    localparam int BYTE_W     = 8;
    // Byte address bits below the word index.
    localparam int WORD_LSB   = 2;

    function automatic logic is_misaligned(input logic [WORD_LSB-1:0] lsbs);
        return lsbs != '0;
    endfunction

endpackage

// File: rtl/aqua_sram_array.sv
// Word-addressed synchronous SRAM with per-byte write enables and a registered
// read port that holds its value when no read is requested.
module aqua_sram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [aqua_mem_pkg::BYTE_LANES-1:0] be,
    input  logic                                re,
    input  logic [IDX_W-1:0]                    addr,
    input  logic [DATA_WIDTH-1:0]               wdata,
    output logic [DATA_WIDTH-1:0]               rdata
);
    import aqua_mem_pkg::*;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (we && be[i]) begin
                mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/aqua_mem_ctrl.sv
// Single-port memory controller: latches one load/store, inserts wait states,
// performs the access on aqua_sram_array and returns a one-cycle ready pulse.
module aqua_mem_ctrl #(
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DEPTH_WORDS    = 1024,
    parameter int WAIT_CYCLES    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      memReq,
    input  logic                      memWr,
    input  logic [MEM_ADDR_WIDTH-1:0] memAddr,
    input  logic [MEM_DATA_WIDTH-1:0] memWrData,
    input  logic [3:0]                memByteEn,
    output logic [MEM_DATA_WIDTH-1:0] memRdData,
    output logic                      memReady,
    output logic                      memErr,
    output logic                      memBusy,
    output logic [2:0]                dbg_state
);
    import aqua_mem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [MEM_ADDR_WIDTH-3:0] DEPTH_LIM = (MEM_ADDR_WIDTH-2)'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    mem_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic ready_q, ready_d;
    logic err_q, err_d;
    logic rd_valid_q, rd_valid_d;

    logic                      wr_q, wr_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [MEM_DATA_WIDTH-1:0] data_q, data_d;
    logic [BYTE_LANES-1:0]     be_q, be_d;

    logic                      req_bad;
    logic                      sram_we;
    logic                      sram_re;
    logic [MEM_DATA_WIDTH-1:0] sram_rdata;

    assign req_bad = is_misaligned(memAddr[WORD_LSB-1:0]) ||
                     (memAddr[MEM_ADDR_WIDTH-1:WORD_LSB] >= DEPTH_LIM);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        rd_valid_d = rd_valid_q;
        wr_d       = wr_q;
        idx_d      = idx_q;
        data_d     = data_q;
        be_d       = be_q;
        case (state_q)
            S_IDLE: begin
                if (memReq) begin
                    wr_d   = memWr;
                    idx_d  = memAddr[IDX_W+WORD_LSB-1:WORD_LSB];
                    data_d = memWrData;
                    be_d   = memByteEn;
                    if (req_bad) begin
                        state_d = S_ERR;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                ready_d = 1'b1;
                if (!wr_q) begin
                    rd_valid_d = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        wr_q   <= wr_d;
        idx_q  <= idx_d;
        data_q <= data_d;
        be_q   <= be_d;
    end

    // Reset landing in ACCESS must leave the array and read register untouched.
    assign sram_we = (state_q == S_ACCESS) && wr_q && !reset;
    assign sram_re = (state_q == S_ACCESS) && !wr_q && !reset;

    aqua_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .DATA_WIDTH (MEM_DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_sram (
        .clk  (clk),
        .we   (sram_we),
        .be   (be_q),
        .re   (sram_re),
        .addr (idx_q),
        .wdata(data_q),
        .rdata(sram_rdata)
    );

    // The array read register has no reset, so report zero until the first load.
    assign memRdData = rd_valid_q ? sram_rdata : '0;
    assign memReady  = ready_q;
    assign memErr    = err_q;
    assign memBusy   = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aqua_mem_ctrl.sv
// Directed bench for aqua_mem_ctrl: one instance with two wait states, one with none.
module tb_aqua_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req   [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        err   [2];
    logic        busy  [2];
    logic [2:0]  dbg   [2];

    int tests = 0;
    int fails = 0;

    aqua_mem_ctrl #(
        .MEM_DATA_WIDTH(32), .MEM_ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)
    ) dut0 (
        .clk(clk), .reset(reset), .memReq(req[0]), .memWr(wr[0]), .memAddr(addr[0]),
        .memWrData(wdata[0]), .memByteEn(be[0]), .memRdData(rdata[0]), .memReady(ready[0]),
        .memErr(err[0]), .memBusy(busy[0]), .dbg_state(dbg[0])
    );

    aqua_mem_ctrl #(
        .MEM_DATA_WIDTH(32), .MEM_ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)
    ) dut1 (
        .clk(clk), .reset(reset), .memReq(req[1]), .memWr(wr[1]), .memAddr(addr[1]),
        .memWrData(wdata[1]), .memByteEn(be[1]), .memRdData(rdata[1]), .memReady(ready[1]),
        .memErr(err[1]), .memBusy(busy[1]), .dbg_state(dbg[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic idle_inputs(input int s);
        req[s]   = 1'b0;
        wr[s]    = 1'b0;
        addr[s]  = 32'h0;
        wdata[s] = 32'h0;
        be[s]    = 4'h0;
    endtask

    // Issue one request, wait (bounded) for memReady, then check latency, error
    // flag, read data and the busy profile around the transaction.
    task automatic xfer(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_rd, input logic toggle, input string tag);
        int   lat;
        logic busy1;
        req[s]   = 1'b1;
        wr[s]    = w;
        addr[s]  = a;
        wdata[s] = d;
        be[s]    = b;
        lat      = 0;
        busy1    = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) busy1 = busy[s];
            if (ready[s]) begin
                lat = n;
                break;
            end
            if (toggle) begin
                addr[s]  = $urandom;
                wdata[s] = $urandom;
                wr[s]    = 1'($urandom_range(0, 1));
                be[s]    = 4'($urandom_range(0, 15));
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_err"}, {31'b0, err[s]}, {31'b0, exp_err});
        chk({tag, "_rd"}, rdata[s], exp_rd);
        chk({tag, "_busy1"}, {31'b0, busy1}, 32'd1);
        idle_inputs(s);
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, {31'b0, busy[s]}, 32'd0);
        chk({tag, "_ready_after"}, {31'b0, ready[s]}, 32'd0);
    endtask

    initial begin
        idle_inputs(0);
        idle_inputs(1);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_ready%0d", s), {31'b0, ready[s]}, 32'd0);
            chk($sformatf("rst_err%0d", s), {31'b0, err[s]}, 32'd0);
            chk($sformatf("rst_busy%0d", s), {31'b0, busy[s]}, 32'd0);
            chk($sformatf("rst_rd%0d", s), rdata[s], 32'd0);
            chk($sformatf("rst_state%0d", s), {29'b0, dbg[s]}, 32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // Zero wait states: success at 2 edges, error at 1.
        xfer(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 1'b0, 32'h0, 1'b0, "w0_st_full");
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 2, 1'b0, 32'hDEADBEEF, 1'b0, "w0_ld_full");
        xfer(1, 1'b1, 32'h10, 32'h12345678, 4'b0011, 2, 1'b0, 32'hDEADBEEF, 1'b0, "w0_st_part");
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 2, 1'b0, 32'hDEAD5678, 1'b0, "w0_ld_part");
        xfer(1, 1'b0, 32'h11, 32'h0, 4'h0, 1, 1'b1, 32'hDEAD5678, 1'b0, "w0_ld_misal");
        xfer(1, 1'b1, 32'h1000, 32'h0, 4'hF, 1, 1'b1, 32'hDEAD5678, 1'b0, "w0_st_oor");

        // Two wait states: success at 4 edges, error at 1.
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4, 1'b0, 32'h0, 1'b0, "st_full");
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 4, 1'b0, 32'hDEADBEEF, 1'b0, "ld_full");
        xfer(0, 1'b1, 32'h10, 32'h12345678, 4'b0011, 4, 1'b0, 32'hDEADBEEF, 1'b0, "st_part");
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 4, 1'b0, 32'hDEAD5678, 1'b0, "ld_part");
        xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 4, 1'b0, 32'hDEAD5678, 1'b0, "st_be0");
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 4, 1'b0, 32'hDEAD5678, 1'b0, "ld_be0");
        xfer(0, 1'b0, 32'h11, 32'h0, 4'h0, 1, 1'b1, 32'hDEAD5678, 1'b0, "ld_misal");
        xfer(0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 4, 1'b0, 32'hDEAD5678, 1'b0, "st_zero");
        xfer(0, 1'b1, 32'h1000, 32'h0, 4'hF, 1, 1'b1, 32'hDEAD5678, 1'b0, "st_oor");
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 4, 1'b0, 32'hA5A5A5A5, 1'b0, "ld_zero");
        xfer(0, 1'b1, 32'hFFC, 32'h0BADC0DE, 4'hF, 4, 1'b0, 32'hA5A5A5A5, 1'b0, "st_top");
        xfer(0, 1'b0, 32'hFFC, 32'h0, 4'h0, 4, 1'b0, 32'h0BADC0DE, 1'b0, "ld_top");

        // Inputs scrambled while busy; then back-to-back loads at minimum spacing.
        xfer(0, 1'b1, 32'h14, 32'h55AA55AA, 4'hF, 4, 1'b0, 32'h0BADC0DE, 1'b1, "st_toggle");
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 4, 1'b0, 32'hDEAD5678, 1'b1, "ld_toggle");
        xfer(0, 1'b0, 32'h14, 32'h0, 4'h0, 4, 1'b0, 32'h55AA55AA, 1'b0, "ld_b2b");

        // Reset landing in ACCESS aborts the store.
        xfer(0, 1'b1, 32'h20, 32'h11112222, 4'hF, 4, 1'b0, 32'h55AA55AA, 1'b0, "st_prior");
        req[0]   = 1'b1;
        wr[0]    = 1'b1;
        addr[0]  = 32'h20;
        wdata[0] = 32'hCAFEF00D;
        be[0]    = 4'hF;
        @(posedge clk); #1;
        chk("rstacc_wait1", {29'b0, dbg[0]}, 32'd1);
        @(posedge clk); #1;
        chk("rstacc_wait2", {29'b0, dbg[0]}, 32'd1);
        @(posedge clk); #1;
        chk("rstacc_access", {29'b0, dbg[0]}, 32'd2);
        chk("rstacc_noready", {31'b0, ready[0]}, 32'd0);
        reset = 1'b1;
        idle_inputs(0);
        @(posedge clk); #1;
        chk("rstacc_ready", {31'b0, ready[0]}, 32'd0);
        chk("rstacc_err", {31'b0, err[0]}, 32'd0);
        chk("rstacc_busy", {31'b0, busy[0]}, 32'd0);
        chk("rstacc_rd", rdata[0], 32'd0);
        chk("rstacc_state", {29'b0, dbg[0]}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rstacc_ready_post", {31'b0, ready[0]}, 32'd0);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 4, 1'b0, 32'h11112222, 1'b0, "ld_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aqua_mem_ctrl.md
# aqua_mem_ctrl

Single-port memory controller that sits directly downstream of the core's TDM arbiter memory interface. It accepts one word-wide load or store at a time and applies a programmable number of wait states. It performs the access on an internal word-addressed SRAM array and returns a one-cycle ready pulse, with read data or an error flag. It is the backing store used for the pygmy core's instruction and data traffic in simulation and on small FPGA builds.

## Interface
- MEM_DATA_WIDTH, 32, data word width; must be 32 (byte enables are 4 bits).
- MEM_ADDR_WIDTH, 32, byte address width.
- DEPTH_WORDS, 1024, number of words in the array.
- WAIT_CYCLES, 2, wait states inserted before the array access (0 allowed).

Clocking: one clock; reset is synchronous and active-high.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- memReq  in  1  request; level, held by the requester until memReady.
- memWr  in  1  1 = store, 0 = load; qualified by memReq.
- memAddr  in  MEM_ADDR_WIDTH  byte address.
- memWrData  in  MEM_DATA_WIDTH  store data.
- memByteEn  in  4  store byte lanes; bit i controls bits [8i+7:8i]; ignored on loads.
- memRdData  out  MEM_DATA_WIDTH  load data; valid while memReady=1 for a successful load.
- memReady  out  1  one-cycle completion pulse.
- memErr  out  1  asserted with memReady when the request was rejected.
- memBusy  out  1  high whenever the FSM is not in IDLE.

## Operation
- States: IDLE, WAIT, ACCESS, RESP, ERR.
- IDLE, memReq=0: stay in IDLE.
- IDLE, memReq=1: latch addr, wr, data and byteEn.
  - Misaligned request (memAddr[1:0]≠0) or out-of-range request (memAddr[MEM_ADDR_WIDTH-1:2] ≥ DEPTH_WORDS) goes to ERR.
  - Otherwise, if WAIT_CYCLES>0, go to WAIT and load the counter with WAIT_CYCLES-1.
  - Otherwise, go to ACCESS.
- WAIT: decrement the counter. Exit to ACCESS on the cycle the counter reads 0. Total time in WAIT is exactly WAIT_CYCLES cycles.
- ACCESS:
  - Store: write the enabled byte lanes of the latched data. memByteEn=0 writes nothing but still completes.
  - Load: registered read of the full word into memRdData.
  - Next state is RESP.
- RESP: memReady=1, memErr=0; next state is IDLE.
- ERR: memReady=1, memErr=1; next state is IDLE. The array is not touched and memRdData is unchanged.
- memRdData holds its last load value through stores, errors and idle cycles.
- memReq while memBusy=1 is ignored; latched fields never change mid-transaction.
- Requester rule: deassert memReq in the cycle after memReady unless issuing a new request. A request sampled in IDLE is always a new transaction.
- Reset values: state IDLE, memReady 0, memErr 0, memBusy 0, memRdData 0, counter 0. Array contents are not reset.
- Reset has priority over every transition. Reset asserted in ACCESS suppresses the write and aborts the transaction with no memReady.

## Timing
- Request sampled in IDLE at edge T: memBusy=1 from T+1.
- Successful access: memReady at cycle T+WAIT_CYCLES+2 (T+2 when WAIT_CYCLES=0).
- Rejected access: memReady and memErr at T+1.
- memBusy drops in the cycle after memReady.
- Minimum request-to-request spacing: WAIT_CYCLES+3 cycles for success, 2 cycles for error.
- Outputs come directly from registers or state decode; there is no combinational path from inputs to outputs.

## Structure
- Shared package aqua_mem_pkg holds:
  - state encodings (3-bit localparams);
  - the byte-lane count localparam;
  - the word-index slice helper constants.
  These are reused by the arbiter bench and future cache blocks.
- Sub-module aqua_sram_array is a DEPTH_WORDS×32 synchronous array with a per-byte write enable and a registered read port. It contains no reset logic.
- The top level holds the FSM, wait counter, request latches, range/alignment check and output registers.

## Test plan
All scenarios use WAIT_CYCLES=2, DEPTH_WORDS=1024.

- Store 0xDEADBEEF to 0x10, byteEn=4'hF, request at T → memReady at T+4, memErr=0. Then load 0x10 → memRdData=0xDEADBEEF with memReady.
- Store 0x12345678 to 0x10, byteEn=4'b0011 → a following load of 0x10 returns 0xDEAD5678. A store with byteEn=0 completes and leaves the value unchanged.
- Misaligned load at 0x11 → memReady=memErr=1 at T+1 and memRdData unchanged. Out-of-range store at 0x1000 → error at T+1; a load of 0x0 shows no write occurred.
- Toggle memAddr and memWrData while memBusy=1 → the original latched request completes unaffected. Back-to-back loads of 0x10 and 0x14 complete at the correct spacing.
- Store 0xCAFEF00D to 0x20 with reset pulsed in the ACCESS cycle → no memReady, all outputs 0 after reset. A following load of 0x20 returns the prior value.
- Same stores and loads with WAIT_CYCLES=0 → memReady at T+2.
